sram_port_arbiter: RTL and testbench

//  Shares one SRAM-like port of an AXI adapter between two SRAM-like requesters (m0 = instruction, m1 = data).

---
 rtl/sram_port_arbiter.sv | 122 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter sharing one SRAM-like adapter port, one transaction in flight.
// `define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise m1 (data) wins ties.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_en,
  input  logic [SEL_WIDTH-1:0]  m0_write_en,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_write_data,
  output logic [DATA_WIDTH-1:0] m0_read_data,
  output logic                  m0_done,
  input  logic                  m1_en,
  input  logic [SEL_WIDTH-1:0]  m1_write_en,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_write_data,
  output logic [DATA_WIDTH-1:0] m1_read_data,
  output logic                  m1_done,
  output logic                  s_en,
  output logic [SEL_WIDTH-1:0]  s_write_en,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_write_data,
  input  logic [DATA_WIDTH-1:0] s_read_data,
  input  logic                  s_ready,
  output logic                  busy,
  output logic                  grant,
  output logic [1:0]            fsm_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0] state;
  logic       waited;
  logic       pick;

`ifdef ARB_ROUND_ROBIN_EN
  // Last granted requester; reset to 1 so the first tie goes to m0.
  logic rr_last;

  always_comb begin
    pick = m1_en;
    if (m0_en && m1_en) pick = ~rr_last;
  end

  always_ff @(posedge clk) begin
    if (!rst) rr_last <= 1'b1;
    else if (state == IDLE && s_ready && (m0_en || m1_en)) rr_last <= pick;
  end
`else
  // Fixed priority: any m1 request wins, a lone m0 request gets through.
  always_comb begin
    pick = m1_en;
  end
`endif

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      waited       <= 1'b0;
      s_en         <= 1'b0;
      s_write_en   <= '0;
      s_addr       <= '0;
      s_write_data <= '0;
      m0_done      <= 1'b0;
      m1_done      <= 1'b0;
      m0_read_data <= '0;
      m1_read_data <= '0;
      busy         <= 1'b0;
      grant        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Hold off while the adapter is still finishing a previous job.
          if ((m0_en || m1_en) && s_ready) begin
            grant        <= pick;
            s_en         <= 1'b1;
            s_write_en   <= pick ? m1_write_en   : m0_write_en;
            s_addr       <= pick ? m1_addr       : m0_addr;
            s_write_data <= pick ? m1_write_data : m0_write_data;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          s_en   <= 1'b0;
          waited <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          // First WAIT cycle is skipped: s_ready may not have dropped yet.
          if (!waited) begin
            waited <= 1'b1;
          end else if (s_ready) begin
            if (grant) begin
              m1_read_data <= s_read_data;
              m1_done      <= 1'b1;
            end else begin
              m0_read_data <= s_read_data;
              m0_done      <= 1'b1;
            end
            state <= RESP;
          end
        end
        default: begin
          m0_done <= 1'b0;
          m1_done <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with an adapter model and request/response scoreboards.
module tb_sram_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int CW = SW + AW + DW;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_en, m1_en;
  logic [SW-1:0] m0_write_en, m1_write_en;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_write_data, m1_write_data;
  logic [DW-1:0] m0_read_data, m1_read_data;
  logic          m0_done, m1_done;
  logic          s_en;
  logic [SW-1:0] s_write_en;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_write_data;
  logic [DW-1:0] s_read_data;
  logic          s_ready;
  logic          busy, grant;
  logic [1:0]    fsm_state;

  int errors = 0;
  int checks = 0;
  int sen_cnt = 0;
  int lat = 4;
  int cnt;
  logic [AW-1:0] adp_addr;
  logic [CW-1:0] exp_q[$];
  logic [DW:0]   exp_d_q[$];
  logic [DW-1:0] last_rd[2];
  logic [DW-1:0] wd[4];

  sram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_en(m0_en), .m0_write_en(m0_write_en), .m0_addr(m0_addr),
    .m0_write_data(m0_write_data), .m0_read_data(m0_read_data), .m0_done(m0_done),
    .m1_en(m1_en), .m1_write_en(m1_write_en), .m1_addr(m1_addr),
    .m1_write_data(m1_write_data), .m1_read_data(m1_read_data), .m1_done(m1_done),
    .s_en(s_en), .s_write_en(s_write_en), .s_addr(s_addr), .s_write_data(s_write_data),
    .s_read_data(s_read_data), .s_ready(s_ready),
    .busy(busy), .grant(grant), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return (a == 32'h1FC0_0000) ? 32'hDEAD_BEEF : (a ^ 32'hC3C3_5A5A);
  endfunction

  // Adapter: s_ready drops after an accepted s_en, returns after lat cycles with data.
  always @(posedge clk) begin
    if (!rst) begin
      s_ready     <= 1'b1;
      s_read_data <= '0;
      cnt         <= 0;
      adp_addr    <= '0;
    end else if (s_ready && s_en) begin
      s_ready  <= 1'b0;
      cnt      <= lat;
      adp_addr <= s_addr;
    end else if (!s_ready) begin
      if (cnt <= 1) begin
        s_ready     <= 1'b1;
        s_read_data <= rd_fn(adp_addr);
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_done(input int idx, input logic [DW-1:0] rd, input logic [DW-1:0] other_rd);
    logic [DW:0] e;
    if (exp_d_q.size() == 0) begin
      chk("unexpected_done", CW'(rd), CW'(~rd));
    end else begin
      e = exp_d_q.pop_front();
      chk("done_idx_data", CW'({idx[0], rd}), CW'(e));
    end
    chk("grant_at_done", CW'(grant), CW'(idx));
    chk("loser_rd_kept", CW'(other_rd), CW'(last_rd[1-idx]));
    last_rd[idx] = rd;
  endtask

  task automatic req(input int idx, input logic [SW-1:0] we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input bit keep);
    int n;
    if (idx == 0) begin
      m0_en = 1'b1; m0_write_en = we; m0_addr = a; m0_write_data = d;
    end else begin
      m1_en = 1'b1; m1_write_en = we; m1_addr = a; m1_write_data = d;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((idx == 0) ? m0_done : m1_done) && n < 500);
    chk("done_seen", CW'((idx == 0) ? m0_done : m1_done), CW'(1));
    if (!keep) begin
      if (idx == 0) m0_en = 1'b0;
      else m1_en = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0;
    m0_en = 1'b1; m0_write_en = '0; m0_addr = 32'h1FC0_0000; m0_write_data = '0;
    m1_en = 1'b0; m1_write_en = '0; m1_addr = '0; m1_write_data = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int i = 0; i < 4; i++) wd[i] = $urandom_range(32'hFFFF_FFFF, 0);

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          last_rd[0] = '0;
          last_rd[1] = '0;
        end else begin
          if (s_en) begin
            sen_cnt++;
            chk("s_ready_at_s_en", CW'(s_ready), CW'(1));
            if (exp_q.size() == 0) chk("unexpected_s_en", CW'(s_en), CW'(0));
            else chk("s_request", {s_write_en, s_addr, s_write_data}, exp_q.pop_front());
          end
          if (m0_done) mon_done(0, m0_read_data, m1_read_data);
          if (m1_done) mon_done(1, m1_read_data, m0_read_data);
          chk("single_done", CW'(m0_done & m1_done), CW'(0));
        end
      end
    join_none

    // Reset held for 3 cycles with m0_en high
    repeat (3) begin
      @(negedge clk);
      chk("rst_s_en", CW'(s_en), CW'(0));
      chk("rst_busy", CW'(busy), CW'(0));
      chk("rst_done", CW'({m0_done, m1_done}), CW'(0));
    end
    chk("rst_s_fields", {s_write_en, s_addr, s_write_data}, CW'(0));
    chk("rst_grant", CW'(grant), CW'(0));
    chk("rst_read_data", CW'({m0_read_data, m1_read_data}), CW'(0));

    // Lone m0 read, adapter busy 4 cycles
    exp_q.push_back({4'h0, 32'h1FC0_0000, 32'h0});
    exp_d_q.push_back({1'b0, 32'hDEAD_BEEF});
    rst = 1'b1;
    req(0, 4'h0, 32'h1FC0_0000, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("one_s_en_pulse", CW'(sen_cnt), CW'(1));

    // Lone m1 partial write
    exp_q.push_back({4'b0011, 32'h8000_0010, 32'h1234_5678});
    exp_d_q.push_back({1'b1, rd_fn(32'h8000_0010)});
    req(1, 4'b0011, 32'h8000_0010, 32'h1234_5678, 1'b0);
    repeat (2) @(negedge clk);

    // Both requesters held high
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back({4'h0, 32'h0000_0100, 32'h0});
    exp_q.push_back({4'hF, 32'h0000_0200, wd[0]});
    exp_q.push_back({4'h0, 32'h0000_0104, 32'h0});
    exp_q.push_back({4'hF, 32'h0000_0204, wd[1]});
    exp_d_q.push_back({1'b0, rd_fn(32'h0000_0100)});
    exp_d_q.push_back({1'b1, rd_fn(32'h0000_0200)});
    exp_d_q.push_back({1'b0, rd_fn(32'h0000_0104)});
    exp_d_q.push_back({1'b1, rd_fn(32'h0000_0204)});
    fork
      begin
        req(0, 4'h0, 32'h0000_0100, 32'h0, 1'b1);
        req(0, 4'h0, 32'h0000_0104, 32'h0, 1'b0);
      end
      begin
        req(1, 4'hF, 32'h0000_0200, wd[0], 1'b1);
        req(1, 4'hF, 32'h0000_0204, wd[1], 1'b0);
      end
    join
`else
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({4'hF, 32'h0000_0200 + 32'(4 * i), wd[i]});
      exp_d_q.push_back({1'b1, rd_fn(32'h0000_0200 + 32'(4 * i))});
    end
    exp_q.push_back({4'h0, 32'h0000_0100, 32'h0});
    exp_d_q.push_back({1'b0, rd_fn(32'h0000_0100)});
    fork
      req(0, 4'h0, 32'h0000_0100, 32'h0, 1'b0);
      begin
        for (int i = 0; i < 4; i++)
          req(1, 4'hF, 32'h0000_0200 + 32'(4 * i), wd[i], i < 3);
      end
    join
`endif
    repeat (2) @(negedge clk);

    // m1 arrives while m0 sits in WAIT
    lat = 6;
    exp_q.push_back({4'h0, 32'h0000_0300, 32'h0});
    exp_q.push_back({4'h4, 32'h0000_0400, wd[2]});
    exp_d_q.push_back({1'b0, rd_fn(32'h0000_0300)});
    exp_d_q.push_back({1'b1, rd_fn(32'h0000_0400)});
    fork
      req(0, 4'h0, 32'h0000_0300, 32'h0, 1'b0);
      begin
        repeat (3) @(negedge clk);
        chk("m0_in_wait", CW'(fsm_state), CW'(ST_WAIT));
        req(1, 4'h4, 32'h0000_0400, wd[2], 1'b0);
      end
    join
    repeat (2) @(negedge clk);

    // Reset during WAIT, then the held m0 request is reissued
    lat = 8;
    exp_q.push_back({4'h0, 32'h0000_0500, 32'h0});
    fork
      req(0, 4'h0, 32'h0000_0500, 32'h0, 1'b0);
      begin
        repeat (4) @(negedge clk);
        chk("pre_rst_wait", CW'(fsm_state), CW'(ST_WAIT));
        rst = 1'b0;
        exp_q.push_back({4'h0, 32'h0000_0500, 32'h0});
        exp_d_q.push_back({1'b0, rd_fn(32'h0000_0500)});
        repeat (2) begin
          @(negedge clk);
          chk("midrst_no_done", CW'({m0_done, m1_done}), CW'(0));
          chk("midrst_idle", CW'({busy, s_en}), CW'(0));
        end
        rst = 1'b1;
      end
    join

    repeat (4) @(negedge clk);
    chk("exp_q_drained", CW'(exp_q.size()), CW'(0));
    chk("exp_d_q_drained", CW'(exp_d_q.size()), CW'(0));
    chk("idle_at_end", CW'(busy), CW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
